sram_arbiter: RTL

Two-requester controller that shares the single 16-bit external SRAM between the LC-3 processor and a second master (program loader / debug port). It sits between the requesters and the SRAM pins, alongside the top level's memory path. It sequences every access as a fixed-length SRAM cycle with active-low strobes and arbitrates contending requests round-robin. It returns read data and a one-cycle acknowledge to the winner.

---
 rtl/sram_arb_pkg.sv | 7 +
 rtl/sram_arbiter.sv | 94 +++++++++
 2 files changed

// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared types and widths for the SRAM arbiter
package sram_arb_pkg;
  localparam int SRAM_ADDR_W = 20;
  localparam int SRAM_DATA_W = 16;
  typedef enum logic [1:0] {IDLE, ACCESS, RECOVER} arb_state_t;
  typedef logic grant_t;
endpackage

// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin two-master controller for a shared asynchronous 16-bit SRAM
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ACCESS_CYCLES = 2,
  parameter int ADDR_W = SRAM_ADDR_W,
  parameter int DATA_W = SRAM_DATA_W
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              R0_Req,
  input  logic              R0_Wr,
  input  logic [1:0]        R0_BE,
  input  logic [ADDR_W-1:0] R0_Addr,
  input  logic [DATA_W-1:0] R0_Wdata,
  output logic              R0_Ack,
  output logic [DATA_W-1:0] R0_Rdata,
  input  logic              R1_Req,
  input  logic              R1_Wr,
  input  logic [1:0]        R1_BE,
  input  logic [ADDR_W-1:0] R1_Addr,
  input  logic [DATA_W-1:0] R1_Wdata,
  output logic              R1_Ack,
  output logic [DATA_W-1:0] R1_Rdata,
  output logic              CE,
  output logic              OE,
  output logic              WE,
  output logic              UB,
  output logic              LB,
  output logic [ADDR_W-1:0] A,
  output logic [DATA_W-1:0] D_out,
  output logic              D_drive,
  input  logic [DATA_W-1:0] D_in
);
  localparam int CW = $clog2(ACCESS_CYCLES) + 1;
  arb_state_t state, state_next;
  logic [CW-1:0] cnt;
  grant_t gid, last_grant, win;
  logic wr, start, done, sel_wr;
  logic [1:0] sel_be;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  always_comb begin
    win = (R0_Req && R1_Req) ? ~last_grant : R1_Req;
    sel_wr = win ? R1_Wr : R0_Wr;
    sel_be = win ? R1_BE : R0_BE;
    sel_addr = win ? R1_Addr : R0_Addr;
    sel_wdata = win ? R1_Wdata : R0_Wdata;
    start = (state == IDLE) && (R0_Req || R1_Req);
    done = (state == ACCESS) && (cnt == '0);
    state_next = start ? ACCESS : done ? RECOVER : (state == RECOVER) ? IDLE : state;
  end
  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else state <= state_next;
  end
  // A and D_out double as the latched request; strobes only move on ACCESS entry/exit
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt <= '0;
      gid <= 1'b0;
      last_grant <= 1'b1;
      wr <= 1'b0;
      {CE, OE, WE, UB, LB} <= 5'b11111;
      D_drive <= 1'b0;
      A <= '0;
      D_out <= '0;
      R0_Ack <= 1'b0;
      R1_Ack <= 1'b0;
      R0_Rdata <= '0;
      R1_Rdata <= '0;
    end else begin
      R0_Ack <= done && !gid;
      R1_Ack <= done && gid;
      if (start) begin
        gid <= win;
        last_grant <= win;
        wr <= sel_wr;
        cnt <= CW'(ACCESS_CYCLES - 1);
        {CE, OE, WE, UB, LB} <= {1'b0, sel_wr, ~sel_wr, ~sel_be[1], ~sel_be[0]};
        D_drive <= sel_wr;
        A <= sel_addr;
        if (sel_wr) D_out <= sel_wdata;
      end
      if (state == ACCESS && !done) cnt <= cnt - 1'b1;
      if (done) begin
        {CE, OE, WE, UB, LB} <= 5'b11111;
        D_drive <= 1'b0;
        if (!wr && !gid) R0_Rdata <= D_in;
        if (!wr && gid) R1_Rdata <= D_in;
      end
    end
  end
endmodule
